// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset clear sweep and optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regwrite,
    input  logic [ADDR_W-1:0]        writebackreg,
    input  logic [DATA_W-1:0]        data_towrite_mem_wb,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     init_busy,
    output logic [ADDR_W-1:0]        clr_ptr_o
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              ready;

    // An address is live only if it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok     = regwrite && addr_ok(writebackreg);
    assign ready     = (state == ST_READY) && !rst;
    assign init_busy = rst || (state == ST_CLEAR);
    assign clr_ptr_o = clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
            if (clr_ptr == LAST_ADDR) begin
                state   <= ST_READY;
                clr_ptr <= '0;
            end else begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end else if (wr_ok) begin
            mem[writebackreg] <= data_towrite_mem_wb;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = '0;
            if (ready && addr_ok(ra)) begin
`ifdef REGFILE_BYPASS_EN
                if (regwrite && (writebackreg == ra)) begin
                    val = data_towrite_mem_wb;
                end else begin
                    val = mem[ra];
                end
`else
                val = mem[ra];
`endif
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
    end

endmodule
